// File: rtl/csi2_pixel_unpacker.sv
// CSI-2 long-packet payload unpacker: RAW8/RAW10/RAW12 bytes to one MSB-aligned
// pixel per cycle, with VC filtering, framing strobes and length/data-type errors.
module csi2_pixel_unpacker #(
  parameter int PIX_W  = 12,
  parameter int VC_SEL = 0,
  parameter int VC_ANY = 0,
  parameter int WC_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hdr_valid,
  input  logic [7:0]       hdr_id,
  input  logic [1:0]       hdr_vc,
  input  logic [WC_W-1:0]  hdr_wc,
  input  logic             hdr_ecc_err,
  input  logic             byte_valid,
  input  logic [7:0]       byte_in,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_data,
  output logic [WC_W-1:0]  pix_cnt,
  output logic             line_start,
  output logic             line_end,
  output logic             frame_start,
  output logic             frame_end,
  output logic             len_err,
  output logic             unsup_dt,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, RAW8, RAW10, RAW12, SKIP} state_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             ls;
    logic             le;
  } ent_t;

  state_t          state, state_nx;
  logic [WC_W-1:0] byte_cnt, byte_cnt_nx;
  logic [2:0]      grp_idx, grp_idx_nx;
  logic            first_grp, first_nx;
  logic [7:0]      msb [4];
  logic            msb_we;

  ent_t            hold [4];
  ent_t            hold_nx [4];
  logic [2:0]      hold_cnt, hold_cnt_nx;
  ent_t            grp [4];
  logic [2:0]      grp_n;
  ent_t            tmp [8];
  logic [3:0]      total;

  logic            hdr_ok, is_long, take;
  logic            last_byte, last_grp;
  logic            len_err_nx, unsup_nx;
  logic [2:0]      gsize;
  logic [WC_W-1:0] rem;

  assign hdr_ok  = hdr_valid & ~hdr_ecc_err & ((VC_ANY != 0) | (hdr_vc == 2'(VC_SEL)));
  assign is_long = hdr_ok & (hdr_id >= 8'h10);
  assign take    = byte_valid & ~is_long & (state != IDLE) & (byte_cnt != '0);
  assign busy    = (state != IDLE);

  always_comb begin
    case (state)
      RAW10:   gsize = 3'd5;
      RAW12:   gsize = 3'd3;
      default: gsize = 3'd1;
    endcase
  end

  // A group is the last complete one when fewer than a full group of bytes remain after it.
  assign last_byte = (grp_idx == gsize - 3'd1);
  assign rem       = byte_cnt - WC_W'(1);
  assign last_grp  = rem < WC_W'(gsize);

  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    grp_idx_nx  = grp_idx;
    first_nx    = first_grp;
    len_err_nx  = 1'b0;
    unsup_nx    = 1'b0;
    msb_we      = 1'b0;
    grp_n       = '0;
    for (int k = 0; k < 4; k++) grp[k] = '0;

    if (is_long) begin
      len_err_nx  = busy;
      grp_idx_nx  = '0;
      first_nx    = 1'b1;
      byte_cnt_nx = hdr_wc;
      unsup_nx    = !(hdr_id inside {8'h2A, 8'h2B, 8'h2C});
      if (hdr_wc == '0) begin
        state_nx = IDLE;
      end else begin
        case (hdr_id)
          8'h2A:   state_nx = RAW8;
          8'h2B:   state_nx = RAW10;
          8'h2C:   state_nx = RAW12;
          default: state_nx = SKIP;
        endcase
      end
    end else if (take) begin
      byte_cnt_nx = byte_cnt - WC_W'(1);
      if (byte_cnt == WC_W'(1)) state_nx = IDLE;
      if (state != SKIP) begin
        if (last_byte) begin
          grp_idx_nx = '0;
          first_nx   = 1'b0;
          case (state)
            RAW8: begin
              grp_n = 3'd1;
              grp[0].data[PIX_W-1 -: 8] = byte_in;
              grp[0].ls = first_grp;
              grp[0].le = last_grp;
            end
            RAW10: begin
              grp_n = 3'd4;
              for (int k = 0; k < 4; k++) begin
                grp[k].data[PIX_W-1 -: 10] = {msb[k], byte_in[2*k +: 2]};
                grp[k].ls = first_grp && (k == 0);
                grp[k].le = last_grp && (k == 3);
              end
            end
            RAW12: begin
              grp_n = 3'd2;
              grp[0].data[PIX_W-1 -: 12] = {msb[0], byte_in[3:0]};
              grp[1].data[PIX_W-1 -: 12] = {msb[1], byte_in[7:4]};
              grp[0].ls = first_grp;
              grp[1].le = last_grp;
            end
            default: ;
          endcase
        end else begin
          grp_idx_nx = grp_idx + 3'd1;
          msb_we     = 1'b1;
          len_err_nx = (byte_cnt == WC_W'(1));
        end
      end
    end
  end

  // Pending tail pixels go out first; a freshly completed group queues behind them.
  always_comb begin
    for (int j = 0; j < 8; j++) tmp[j] = '0;
    for (int j = 0; j < 4; j++) begin
      if (j < int'(hold_cnt)) tmp[j] = hold[j];
    end
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 4; k++) begin
        if ((k < int'(grp_n)) && (j == int'(hold_cnt) + k)) tmp[j] = grp[k];
      end
    end
    total = {1'b0, hold_cnt} + {1'b0, grp_n};
    for (int j = 0; j < 4; j++) hold_nx[j] = tmp[j+1];
    if (total == 4'd0)      hold_cnt_nx = 3'd0;
    else if (total > 4'd5)  hold_cnt_nx = 3'd4;
    else                    hold_cnt_nx = 3'(total - 4'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      grp_idx   <= '0;
      first_grp <= 1'b0;
      hold_cnt  <= '0;
      for (int k = 0; k < 4; k++) begin
        msb[k]  <= '0;
        hold[k] <= '0;
      end
    end else begin
      state     <= state_nx;
      byte_cnt  <= byte_cnt_nx;
      grp_idx   <= grp_idx_nx;
      first_grp <= first_nx;
      hold_cnt  <= hold_cnt_nx;
      if (msb_we) msb[grp_idx[1:0]] <= byte_in;
      for (int k = 0; k < 4; k++) hold[k] <= hold_nx[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_cnt     <= '0;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      len_err     <= 1'b0;
      unsup_dt    <= 1'b0;
    end else begin
      pix_valid   <= (total != 4'd0);
      pix_data    <= tmp[0].data;
      line_start  <= tmp[0].ls;
      line_end    <= tmp[0].le;
      if (total != 4'd0) pix_cnt <= tmp[0].ls ? '0 : pix_cnt + WC_W'(1);
      frame_start <= hdr_ok & (hdr_id == 8'h00);
      frame_end   <= hdr_ok & (hdr_id == 8'h01);
      len_err     <= len_err_nx;
      unsup_dt    <= unsup_nx;
    end
  end

endmodule

// File: tb/tb_csi2_pixel_unpacker.sv
// Self-checking bench for csi2_pixel_unpacker: randomized packets compared against
// a packet-level reference model of the unpacking rules.
module tb_csi2_pixel_unpacker;

  localparam int PIX_W = 12;
  localparam int WC_W  = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             hdr_valid = 1'b0;
  logic [7:0]       hdr_id = '0;
  logic [1:0]       hdr_vc = '0;
  logic [WC_W-1:0]  hdr_wc = '0;
  logic             hdr_ecc_err = 1'b0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_in = '0;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic [WC_W-1:0]  pix_cnt;
  logic             line_start, line_end, frame_start, frame_end;
  logic             len_err, unsup_dt, busy;

  csi2_pixel_unpacker #(.PIX_W(PIX_W), .VC_SEL(0), .VC_ANY(0), .WC_W(WC_W)) dut (
    .clk(clk), .reset(reset), .hdr_valid(hdr_valid), .hdr_id(hdr_id), .hdr_vc(hdr_vc),
    .hdr_wc(hdr_wc), .hdr_ecc_err(hdr_ecc_err), .byte_valid(byte_valid), .byte_in(byte_in),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_cnt(pix_cnt), .line_start(line_start),
    .line_end(line_end), .frame_start(frame_start), .frame_end(frame_end),
    .len_err(len_err), .unsup_dt(unsup_dt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PIX_W-1:0] data;
    logic [WC_W-1:0]  cnt;
    logic             ls;
    logic             le;
    int               cyc;
  } pix_t;

  pix_t       obs[$];
  pix_t       exp_q[$];
  logic [7:0] pkt[$];
  int         byte_cyc[$];
  int checks = 0, errors = 0, cyc = 0, hdr_cyc = 0;
  int fs_n = 0, fe_n = 0, len_n = 0, uns_n = 0, busy_n = 0, fs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    pix_t p;
    if (!reset) begin
      if (pix_valid) begin
        p.data = pix_data; p.cnt = pix_cnt; p.ls = line_start; p.le = line_end; p.cyc = cyc;
        obs.push_back(p);
      end
      if (frame_start) begin fs_n++; fs_cyc = cyc; end
      if (frame_end) fe_n++;
      if (len_err) len_n++;
      if (unsup_dt) uns_n++;
      if (busy) busy_n++;
    end
  end

  task automatic clear_obs();
    obs.delete(); exp_q.delete();
    fs_n = 0; fe_n = 0; len_n = 0; uns_n = 0; busy_n = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] id, input logic [1:0] vc, input logic [15:0] wc,
                          input logic ecc);
    hdr_valid = 1'b1; hdr_id = id; hdr_vc = vc; hdr_wc = wc; hdr_ecc_err = ecc;
    @(posedge clk); #1;
    hdr_valid = 1'b0; hdr_ecc_err = 1'b0;
    hdr_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1; byte_in = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_cyc.push_back(cyc);
  endtask

  function automatic logic [PIX_W-1:0] pix_val(input logic [7:0] id, input int base, input int k);
    int v;
    case (id)
      8'h2A:   v = int'(pkt[base]) << 4;
      8'h2B:   v = ((int'(pkt[base+k]) << 2) | ((int'(pkt[base+4]) >> (2*k)) & 3)) << 2;
      default: v = (int'(pkt[base+k]) << 4) |
                   ((k == 0) ? (int'(pkt[base+2]) & 15) : (int'(pkt[base+2]) >> 4));
    endcase
    return PIX_W'(v);
  endfunction

  // Expected pixels for a packet of wc bytes of which nsent were delivered from pkt.
  task automatic model_pkt(input logic [7:0] id, input int wc, input int nsent);
    int g, ppg, nfull;
    pix_t e;
    case (id)
      8'h2A: begin g = 1; ppg = 1; end
      8'h2B: begin g = 5; ppg = 4; end
      8'h2C: begin g = 3; ppg = 2; end
      default: return;
    endcase
    nfull = wc / g;
    for (int gi = 0; gi < nfull && (gi + 1) * g <= nsent; gi++) begin
      for (int k = 0; k < ppg; k++) begin
        e.data = pix_val(id, gi * g, k);
        e.cnt  = WC_W'(gi * ppg + k);
        e.ls   = (gi == 0) && (k == 0);
        e.le   = (gi == nfull - 1) && (k == ppg - 1);
        e.cyc  = byte_cyc[gi * g + g - 1] + k;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_pkt(input logic [7:0] id, input int wc, input int nsend, input int gap_max);
    byte_cyc.delete();
    send_hdr(id, 2'd0, 16'(wc), 1'b0);
    for (int i = 0; i < nsend; i++) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      if (i >= pkt.size()) pkt.push_back(8'($urandom));
      send_byte(pkt[i]);
    end
    model_pkt(id, wc, nsend);
  endtask

  task automatic test_reset();
    idle(2);
    checks++;
    if ({pix_valid, pix_data, pix_cnt, line_start, line_end, frame_start, frame_end,
         len_err, unsup_dt, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h cnt=%0d busy=%b, expected all zero",
               pix_valid, pix_data, pix_cnt, busy);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_frame_raw8();
    int fs_hdr;
    clear_obs();
    send_hdr(8'h00, 2'd0, 16'd0, 1'b0);
    fs_hdr = hdr_cyc;
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(8'h2A, 4, 4, 0);
    send_hdr(8'h01, 2'd0, 16'd0, 1'b0);
    idle(6);
    checks++;
    if (fs_n != 1 || fs_cyc != fs_hdr) begin
      errors++; $display("[TB] FAIL frame_start: got %0d pulses at cyc %0d, expected 1 at %0d", fs_n, fs_cyc, fs_hdr);
    end
    checks++;
    if (fe_n != 1) begin errors++; $display("[TB] FAIL frame_end: got %0d pulses, expected 1", fe_n); end
    checks++;
    if (obs.size() > 0 && obs[0].data !== 12'h110) begin
      errors++; $display("[TB] FAIL raw8_first: got %h expected 110", obs[0].data);
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL raw8_count: got %0d pixels expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].data !== exp_q[i].data || obs[i].cnt !== exp_q[i].cnt || obs[i].ls !== exp_q[i].ls ||
          obs[i].le !== exp_q[i].le || obs[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("[TB] FAIL raw8_pix[%0d]: got %h/%0d/%b%b@%0d expected %h/%0d/%b%b@%0d", i,
                 obs[i].data, obs[i].cnt, obs[i].ls, obs[i].le, obs[i].cyc,
                 exp_q[i].data, exp_q[i].cnt, exp_q[i].ls, exp_q[i].le, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_raw10();
    clear_obs();
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hE4};
    send_pkt(8'h2B, 5, 5, 0);
    idle(6);
    for (int n = 0; n < 3; n++) begin
      pkt.delete();
      send_pkt(8'h2B, 5 * $urandom_range(1, 3), 0, 0);
      exp_q.pop_back();
    end
  endtask

  task automatic test_raw10_random();
    int wc;
    clear_obs();
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hE4};
    send_pkt(8'h2B, 5, 5, 0);
    idle(6);
    for (int n = 0; n < 3; n++) begin
      pkt.delete();
      wc = 5 * $urandom_range(1, 3);
      send_pkt(8'h2B, wc, wc, 1);
      idle(6);
    end
    checks++;
    if (obs.size() != exp_q.size() || len_n != 0) begin
      errors++; $display("[TB] FAIL raw10_count: got %0d pixels len_err=%0d expected %0d pixels len_err=0",
                         obs.size(), len_n, exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].data !== exp_q[i].data || obs[i].cnt !== exp_q[i].cnt || obs[i].ls !== exp_q[i].ls ||
          obs[i].le !== exp_q[i].le || obs[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("[TB] FAIL raw10_pix[%0d]: got %h/%0d/%b%b@%0d expected %h/%0d/%b%b@%0d", i,
                 obs[i].data, obs[i].cnt, obs[i].ls, obs[i].le, obs[i].cyc,
                 exp_q[i].data, exp_q[i].cnt, exp_q[i].ls, exp_q[i].le, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_raw12_len();
    clear_obs();
    pkt = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hFF};
    send_pkt(8'h2C, 7, 7, 0);
    idle(6);
    checks++;
    if (len_n != 1) begin errors++; $display("[TB] FAIL raw12_len_err: got %0d pulses expected 1", len_n); end
    checks++;
    if (obs.size() == 4 && (obs[3].data !== 12'h9AB || obs[3].le !== 1'b1)) begin
      errors++; $display("[TB] FAIL raw12_last: got %h le=%b expected 9ab le=1", obs[3].data, obs[3].le);
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL raw12_count: got %0d pixels expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].data !== exp_q[i].data || obs[i].cnt !== exp_q[i].cnt || obs[i].ls !== exp_q[i].ls ||
          obs[i].le !== exp_q[i].le || obs[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("[TB] FAIL raw12_pix[%0d]: got %h/%0d/%b%b@%0d expected %h/%0d/%b%b@%0d", i,
                 obs[i].data, obs[i].cnt, obs[i].ls, obs[i].le, obs[i].cyc,
                 exp_q[i].data, exp_q[i].cnt, exp_q[i].ls, exp_q[i].le, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_filter();
    clear_obs();
    send_hdr(8'h2A, 2'd1, 16'd8, 1'b0);
    repeat (8) send_byte(8'($urandom));
    send_hdr(8'h2A, 2'd0, 16'd8, 1'b1);
    repeat (8) send_byte(8'($urandom));
    send_hdr(8'h00, 2'd1, 16'd0, 1'b0);
    send_hdr(8'h01, 2'd0, 16'd0, 1'b1);
    idle(5);
    checks++;
    if (obs.size() != 0 || fs_n + fe_n + len_n + uns_n != 0 || busy_n != 0) begin
      errors++;
      $display("[TB] FAIL filter: got pixels=%0d strobes=%0d busy_cycles=%0d, expected all 0",
               obs.size(), fs_n + fe_n + len_n + uns_n, busy_n);
    end
  endtask

  task automatic test_unsup_abort();
    clear_obs();
    pkt.delete();
    send_pkt(8'h2D, 6, 6, 0);
    idle(3);
    checks++;
    if (uns_n != 1 || busy_n != 6 || obs.size() != 0) begin
      errors++;
      $display("[TB] FAIL unsup: got unsup=%0d busy_cycles=%0d pixels=%0d, expected 1/6/0",
               uns_n, busy_n, obs.size());
    end
    clear_obs();
    pkt.delete();
    send_pkt(8'h2B, 10, 3, 0);
    pkt.delete();
    send_pkt(8'h2B, 5, 5, 0);
    idle(6);
    checks++;
    if (len_n != 1 || uns_n != 0) begin
      errors++; $display("[TB] FAIL abort_len_err: got len=%0d unsup=%0d expected 1/0", len_n, uns_n);
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL abort_count: got %0d pixels expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].data !== exp_q[i].data || obs[i].cnt !== exp_q[i].cnt || obs[i].ls !== exp_q[i].ls ||
          obs[i].le !== exp_q[i].le || obs[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("[TB] FAIL abort_pix[%0d]: got %h/%0d/%b%b@%0d expected %h/%0d/%b%b@%0d", i,
                 obs[i].data, obs[i].cnt, obs[i].ls, obs[i].le, obs[i].cyc,
                 exp_q[i].data, exp_q[i].cnt, exp_q[i].ls, exp_q[i].le, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    pkt.delete(); send_pkt(8'h2B, 5, 5, 0);
    pkt.delete(); send_pkt(8'h2A, 3, 3, 0);
    pkt.delete(); send_pkt(8'h2C, 6, 6, 0);
    pkt.delete(); send_pkt(8'h2C, 3, 3, 0);
    pkt.delete();
    for (int i = 0; i < 4; i++) pkt.push_back(8'($urandom));
    byte_cyc.delete();
    send_hdr(8'h2A, 2'd0, 16'd4, 1'b0);
    send_byte(pkt[0]); send_byte(pkt[1]);
    send_hdr(8'h00, 2'd0, 16'd0, 1'b0);
    send_byte(pkt[2]); send_byte(pkt[3]);
    model_pkt(8'h2A, 4, 4);
    idle(8);
    checks++;
    if (fs_n != 1 || len_n != 0) begin
      errors++; $display("[TB] FAIL fs_in_packet: got fs=%0d len=%0d expected 1/0", fs_n, len_n);
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d pixels expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].data !== exp_q[i].data || obs[i].cnt !== exp_q[i].cnt || obs[i].ls !== exp_q[i].ls ||
          obs[i].le !== exp_q[i].le) begin
        errors++;
        $display("[TB] FAIL b2b_pix[%0d]: got %h/%0d/%b%b expected %h/%0d/%b%b", i,
                 obs[i].data, obs[i].cnt, obs[i].ls, obs[i].le,
                 exp_q[i].data, exp_q[i].cnt, exp_q[i].ls, exp_q[i].le);
      end
    end
  endtask

  task automatic test_random();
    int wc, g, n_len;
    logic [7:0] id;
    clear_obs();
    n_len = 0;
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 2))
        0:       begin id = 8'h2A; g = 1; end
        1:       begin id = 8'h2B; g = 5; end
        default: begin id = 8'h2C; g = 3; end
      endcase
      wc = $urandom_range(0, 17);
      if (wc % g != 0) n_len++;
      pkt.delete();
      send_pkt(id, wc, wc, 2);
      idle(6);
    end
    checks++;
    if (len_n != n_len || uns_n != 0) begin
      errors++; $display("[TB] FAIL random_len_err: got %0d/%0d expected %0d/0", len_n, uns_n, n_len);
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL random_count: got %0d pixels expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].data !== exp_q[i].data || obs[i].cnt !== exp_q[i].cnt || obs[i].ls !== exp_q[i].ls ||
          obs[i].le !== exp_q[i].le || obs[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("[TB] FAIL random_pix[%0d]: got %h/%0d/%b%b@%0d expected %h/%0d/%b%b@%0d", i,
                 obs[i].data, obs[i].cnt, obs[i].ls, obs[i].le, obs[i].cyc,
                 exp_q[i].data, exp_q[i].cnt, exp_q[i].ls, exp_q[i].le, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_obs();
    send_hdr(8'h2B, 2'd0, 16'd10, 1'b0);
    repeat (3) send_byte(8'($urandom));
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_mid_packet: got %b expected 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pix_valid, pix_data, pix_cnt, line_start, line_end, frame_start, frame_end,
         len_err, unsup_dt, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got valid=%b data=%h cnt=%0d busy=%b, expected all zero",
               pix_valid, pix_data, pix_cnt, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    clear_obs();
    pkt.delete();
    send_pkt(8'h2A, 3, 3, 0);
    idle(4);
    checks++;
    if (obs.size() != exp_q.size() || len_n != 0) begin
      errors++; $display("[TB] FAIL post_reset_count: got %0d pixels len=%0d expected %0d/0",
                         obs.size(), len_n, exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].data !== exp_q[i].data || obs[i].cnt !== exp_q[i].cnt || obs[i].ls !== exp_q[i].ls ||
          obs[i].le !== exp_q[i].le || obs[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("[TB] FAIL post_reset_pix[%0d]: got %h/%0d/%b%b@%0d expected %h/%0d/%b%b@%0d", i,
                 obs[i].data, obs[i].cnt, obs[i].ls, obs[i].le, obs[i].cyc,
                 exp_q[i].data, exp_q[i].cnt, exp_q[i].ls, exp_q[i].le, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_frame_raw8();
    test_raw10_random();
    test_raw12_len();
    test_filter();
    test_unsup_abort();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
